// File: rtl/i2c_cmd_sequencer_if.sv
// Bundles the command, master-handshake and response signals of i2c_cmd_sequencer.
// The sequencer uses the slave modport; whatever drives commands and models the master uses master.
interface i2c_cmd_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int FIFO_DEPTH = 4
);
   // Command side: a push happens on any clock edge where i_cmd_valid and o_cmd_ready are both high.
   // Response side: a response retires on any edge where o_rsp_valid and i_rsp_ready are both high,
   // and the response fields hold until then.
   logic                         i_cmd_valid;
   logic                         o_cmd_ready;
   logic                         i_cmd_rw;
   logic [REG_WIDTH-1:0]         i_cmd_reg;
   logic [DATA_WIDTH-1:0]        i_cmd_data;
   logic [ADDR_WIDTH-1:0]        i_device_addr;
   logic [15:0]                  i_divider;

   logic                         o_enable;
   logic                         o_rw;
   logic [REG_WIDTH-1:0]         o_reg_addr;
   logic [DATA_WIDTH-1:0]        o_mosi_data;
   logic [ADDR_WIDTH-1:0]        o_device_addr;
   logic [15:0]                  o_divider;
   logic [DATA_WIDTH-1:0]        i_miso_data;
   logic                         i_busy;

   logic                         o_rsp_valid;
   logic                         i_rsp_ready;
   logic                         o_rsp_rw;
   logic [REG_WIDTH-1:0]         o_rsp_reg;
   logic [DATA_WIDTH-1:0]        o_rsp_data;
   logic                         o_rsp_err;

   logic [$clog2(FIFO_DEPTH):0]  o_fifo_count;
   logic                         o_idle;
   logic [2:0]                   o_dbg_state;

   modport slave (
      input  i_cmd_valid, i_cmd_rw, i_cmd_reg, i_cmd_data, i_device_addr, i_divider,
      input  i_miso_data, i_busy, i_rsp_ready,
      output o_cmd_ready, o_enable, o_rw, o_reg_addr, o_mosi_data, o_device_addr, o_divider,
      output o_rsp_valid, o_rsp_rw, o_rsp_reg, o_rsp_data, o_rsp_err,
      output o_fifo_count, o_idle, o_dbg_state
   );

   modport master (
      output i_cmd_valid, i_cmd_rw, i_cmd_reg, i_cmd_data, i_device_addr, i_divider,
      output i_miso_data, i_busy, i_rsp_ready,
      input  o_cmd_ready, o_enable, o_rw, o_reg_addr, o_mosi_data, o_device_addr, o_divider,
      input  o_rsp_valid, o_rsp_rw, o_rsp_reg, o_rsp_data, o_rsp_err,
      input  o_fifo_count, o_idle, o_dbg_state
   );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Queues register read/write commands and plays them one at a time into i2c_master,
// returning one response per command (with a timeout error if the master never goes busy).
module i2c_cmd_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input logic                i_clk,
   input logic                i_rst,
   i2c_cmd_sequencer_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;

   localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ARM  = 3'd2,
      S_RUN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                state;

   logic [FIFO_DEPTH-1:0] fifo_rw;
   logic [REG_WIDTH-1:0]  fifo_reg  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;

   logic [TMO_W-1:0]      tmo_cnt;
   logic                  enable_q;
   logic                  rw_q;
   logic [REG_WIDTH-1:0]  reg_q;
   logic [DATA_WIDTH-1:0] mosi_q;
   logic [ADDR_WIDTH-1:0] dev_q;
   logic [15:0]           div_q;
   logic                  rsp_valid_q;
   logic                  rsp_rw_q;
   logic [REG_WIDTH-1:0]  rsp_reg_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_err_q;

   assign bus.o_cmd_ready = (count != COUNT_FULL);
   assign push            = bus.i_cmd_valid && bus.o_cmd_ready;
   // A busy master in IDLE means someone else's transaction is still on the wire.
   assign pop             = (state == S_IDLE) && (count != '0) && !bus.i_busy;

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_rw[wr_ptr]   <= bus.i_cmd_rw;
         fifo_reg[wr_ptr]  <= bus.i_cmd_reg;
         fifo_data[wr_ptr] <= bus.i_cmd_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= S_IDLE;
         tmo_cnt     <= '0;
         enable_q    <= 1'b0;
         rw_q        <= 1'b0;
         reg_q       <= '0;
         mosi_q      <= '0;
         dev_q       <= '0;
         div_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rw_q    <= 1'b0;
         rsp_reg_q   <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  rw_q   <= fifo_rw[rd_ptr];
                  reg_q  <= fifo_reg[rd_ptr];
                  mosi_q <= fifo_data[rd_ptr];
                  dev_q  <= bus.i_device_addr;
                  div_q  <= bus.i_divider;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               enable_q <= 1'b1;
               tmo_cnt  <= '0;
               state    <= S_ARM;
            end
            S_ARM: begin
               if (bus.i_busy) begin
                  enable_q <= 1'b0;
                  state    <= S_RUN;
               end else if (tmo_cnt == TMO_LAST) begin
                  enable_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_rw_q    <= rw_q;
                  rsp_reg_q   <= reg_q;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_ONE;
               end
            end
            S_RUN: begin
               // Writes echo their own data so every response carries a meaningful byte.
               if (!bus.i_busy) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rw_q    <= rw_q;
                  rsp_reg_q   <= reg_q;
                  rsp_data_q  <= rw_q ? bus.i_miso_data : mosi_q;
                  rsp_err_q   <= 1'b0;
                  state       <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_enable      = enable_q;
   assign bus.o_rw          = rw_q;
   assign bus.o_reg_addr    = reg_q;
   assign bus.o_mosi_data   = mosi_q;
   assign bus.o_device_addr = dev_q;
   assign bus.o_divider     = div_q;
   assign bus.o_rsp_valid   = rsp_valid_q;
   assign bus.o_rsp_rw      = rsp_rw_q;
   assign bus.o_rsp_reg     = rsp_reg_q;
   assign bus.o_rsp_data    = rsp_data_q;
   assign bus.o_rsp_err     = rsp_err_q;
   assign bus.o_fifo_count  = count;
   assign bus.o_idle        = (state == S_IDLE) && (count == '0);
   assign bus.o_dbg_state   = state;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: a register-file stub stands in for i2c_master, a command table
// drives the main traffic, and hand-written sequences cover full FIFO, timeout, backpressure and reset.
module tb_i2c_cmd_sequencer;
   localparam int DW    = 8;
   localparam int RW    = 8;
   localparam int AW    = 7;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
   localparam int EW    = 1 + RW + DW + 1;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   always #5 i_clk = ~i_clk;

   i2c_cmd_sequencer_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

   i2c_cmd_sequencer #(
      .DATA_WIDTH(DW), .REG_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Master stub: goes busy on the first negedge it sees enable, performs the register access,
   // then stays busy for stub_len cycles.
   logic       stub_auto  = 1'b1;
   int         stub_len   = 3;
   logic       force_busy = 1'b0;
   logic       stub_busy  = 1'b0;
   int         busy_left  = 0;
   logic [7:0] miso_q     = 8'h00;
   logic [7:0] model_regs [256];

   assign bus.i_busy      = stub_busy | force_busy;
   assign bus.i_miso_data = miso_q;

   always @(negedge i_clk) begin
      if (stub_busy) begin
         if (busy_left <= 1) stub_busy = 1'b0;
         else busy_left--;
      end else if (stub_auto && bus.o_enable) begin
         stub_busy = 1'b1;
         busy_left = stub_len;
         if (bus.o_rw) miso_q = model_regs[bus.o_reg_addr];
         else model_regs[bus.o_reg_addr] = bus.o_mosi_data;
      end
   end

   // Scoreboard: expected responses as {rw, reg, data, err}.
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int            en_pulses = 0;
   logic          en_prev   = 1'b0;

   always @(negedge i_clk) begin
      if (!i_rst && bus.o_rsp_valid && bus.i_rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rw",   32'(bus.o_rsp_rw),   32'(mon_e[EW-1]));
            check("rsp_reg",  32'(bus.o_rsp_reg),  32'(mon_e[EW-2 -: RW]));
            check("rsp_data", 32'(bus.o_rsp_data), 32'(mon_e[DW:1]));
            check("rsp_err",  32'(bus.o_rsp_err),  32'(mon_e[0]));
         end
      end
      if (bus.o_enable && !en_prev) en_pulses++;
      en_prev = bus.o_enable;
   end

   task automatic push_cmd(input logic rw, input logic [7:0] r, input logic [7:0] d,
                           input logic [7:0] ed, input logic ee);
      int w;
      @(negedge i_clk);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_rw    = rw;
      bus.i_cmd_reg   = r;
      bus.i_cmd_data  = d;
      w = 0;
      while (!bus.o_cmd_ready && w < 500) begin
         @(negedge i_clk);
         w++;
      end
      if (w >= 500) check("push_wait", 32'd0, 32'd1);
      else exp_q.push_back({rw, r, ed, ee});
      @(negedge i_clk);
      bus.i_cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w;
      w = 0;
      while ((exp_q.size() != 0 || !bus.o_idle) && w < 3000) begin
         @(negedge i_clk);
         w++;
      end
      check({name, "_drain"}, 32'(w < 3000), 32'd1);
   endtask

   typedef struct {
      logic       rw;
      logic [7:0] reg_a;
      logic [7:0] data;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #500000;
      check("watchdog", 32'd0, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int base;
      int w;
      int hi;
      int bad_stable;
      int bad_count;
      int bad_en;
      logic [EW-1:0] snap;

      vecs[0] = '{1'b0, 8'h00, 8'hDC, 8'hDC};
      vecs[1] = '{1'b1, 8'h00, 8'h00, 8'hDC};
      vecs[2] = '{1'b0, 8'h01, 8'hAB, 8'hAB};
      vecs[3] = '{1'b0, 8'h02, 8'hEF, 8'hEF};
      vecs[4] = '{1'b1, 8'h01, 8'h00, 8'hAB};
      vecs[5] = '{1'b1, 8'h02, 8'h00, 8'hEF};
      vecs[6] = '{1'b0, 8'h03, 8'h5A, 8'h5A};
      vecs[7] = '{1'b1, 8'h03, 8'h00, 8'h5A};

      bus.i_cmd_valid   = 1'b0;
      bus.i_cmd_rw      = 1'b0;
      bus.i_cmd_reg     = 8'h00;
      bus.i_cmd_data    = 8'h00;
      bus.i_device_addr = 7'h11;
      bus.i_divider     = 16'h0040;
      bus.i_rsp_ready   = 1'b1;

      // Reset state
      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_enable",      32'(bus.o_enable),      32'd0);
      check("rst_rw",          32'(bus.o_rw),          32'd0);
      check("rst_reg_addr",    32'(bus.o_reg_addr),    32'd0);
      check("rst_mosi",        32'(bus.o_mosi_data),   32'd0);
      check("rst_device_addr", 32'(bus.o_device_addr), 32'd0);
      check("rst_divider",     32'(bus.o_divider),     32'd0);
      check("rst_rsp_valid",   32'(bus.o_rsp_valid),   32'd0);
      check("rst_rsp_data",    32'(bus.o_rsp_data),    32'd0);
      check("rst_rsp_err",     32'(bus.o_rsp_err),     32'd0);
      check("rst_idle",        32'(bus.o_idle),        32'd1);
      check("rst_cmd_ready",   32'(bus.o_cmd_ready),   32'd1);
      check("rst_fifo_count",  32'(bus.o_fifo_count),  32'd0);
      i_rst = 1'b0;

      // Table-driven traffic through the stub register file
      base = en_pulses;
      for (int i = 0; i < 8; i++)
         push_cmd(vecs[i].rw, vecs[i].reg_a, vecs[i].data, vecs[i].exp_data, 1'b0);
      wait_drain("table");
      check("table_enable_pulses", 32'(en_pulses - base), 32'd8);
      check("table_device_addr",   32'(bus.o_device_addr), 32'h11);
      check("table_divider",       32'(bus.o_divider),     32'h0040);

      // Fill the FIFO while a foreign transaction holds busy, then release it
      force_busy = 1'b1;
      base = en_pulses;
      push_cmd(1'b0, 8'h00, 8'hDC, 8'hDC, 1'b0);
      push_cmd(1'b0, 8'h01, 8'hAB, 8'hAB, 1'b0);
      push_cmd(1'b0, 8'h02, 8'hEF, 8'hEF, 1'b0);
      push_cmd(1'b1, 8'h01, 8'h00, 8'hAB, 1'b0);
      check("full_count", 32'(bus.o_fifo_count), 32'd4);
      check("full_ready", 32'(bus.o_cmd_ready),  32'd0);
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_rw    = 1'b0;
      bus.i_cmd_reg   = 8'h07;
      bus.i_cmd_data  = 8'h33;
      @(negedge i_clk);
      check("full_fifth_rejected", 32'(bus.o_fifo_count), 32'd4);
      check("full_no_enable",      32'(en_pulses - base),  32'd0);
      bus.i_cmd_valid = 1'b0;
      force_busy = 1'b0;
      wait_drain("full");
      check("full_enable_pulses", 32'(en_pulses - base), 32'd4);

      // Timeout with busy stuck low
      stub_auto = 1'b0;
      push_cmd(1'b0, 8'h05, 8'h77, 8'h00, 1'b1);
      w = 0;
      while (!bus.o_enable && w < 100) begin
         @(negedge i_clk);
         w++;
      end
      check("tmo_enable_rise", 32'(w < 100), 32'd1);
      hi = 0;
      while (bus.o_enable && hi < 100) begin
         hi++;
         @(negedge i_clk);
      end
      check("tmo_enable_len", 32'(hi), 32'(TMO));
      wait_drain("tmo");
      stub_auto = 1'b1;

      // Response backpressure: fields hold and the queued command waits
      @(posedge i_clk);
      #1 bus.i_rsp_ready = 1'b0;
      push_cmd(1'b1, 8'h01, 8'h00, 8'hAB, 1'b0);
      push_cmd(1'b0, 8'h03, 8'h11, 8'h11, 1'b0);
      w = 0;
      while (!bus.o_rsp_valid && w < 200) begin
         @(negedge i_clk);
         w++;
      end
      check("bp_valid_rise", 32'(w < 200), 32'd1);
      check("bp_rsp_data",   32'(bus.o_rsp_data), 32'hAB);
      snap = {bus.o_rsp_rw, bus.o_rsp_reg, bus.o_rsp_data, bus.o_rsp_err};
      base = en_pulses;
      bad_stable = 0;
      bad_count  = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge i_clk);
         if ({bus.o_rsp_rw, bus.o_rsp_reg, bus.o_rsp_data, bus.o_rsp_err} !== snap ||
             !bus.o_rsp_valid) bad_stable++;
         if (bus.o_fifo_count != 1) bad_count++;
      end
      check("bp_stable",    32'(bad_stable),        32'd0);
      check("bp_count",     32'(bad_count),         32'd0);
      check("bp_no_enable", 32'(en_pulses - base),  32'd0);
      @(posedge i_clk);
      #1 bus.i_rsp_ready = 1'b1;
      wait_drain("bp");

      // Reset while the master is mid-transaction
      stub_len = 20;
      push_cmd(1'b0, 8'h06, 8'h99, 8'h99, 1'b0);
      push_cmd(1'b0, 8'h07, 8'h44, 8'h44, 1'b0);
      w = 0;
      while (bus.o_dbg_state != 3'd3 && w < 100) begin
         @(negedge i_clk);
         w++;
      end
      check("rr_reached_run", 32'(w < 100), 32'd1);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      exp_q.delete();
      check("rr_enable",     32'(bus.o_enable),     32'd0);
      check("rr_fifo_count", 32'(bus.o_fifo_count), 32'd0);
      check("rr_idle",       32'(bus.o_idle),       32'd1);
      check("rr_busy_held",  32'(bus.i_busy),       32'd1);
      push_cmd(1'b1, 8'h06, 8'h00, 8'h99, 1'b0);
      bad_en    = 0;
      bad_count = 0;
      w = 0;
      while (bus.i_busy && w < 100) begin
         if (bus.o_enable) bad_en++;
         if (bus.o_fifo_count != 1) bad_count++;
         @(negedge i_clk);
         w++;
      end
      check("rr_busy_fell",   32'(w < 100),   32'd1);
      check("rr_no_pop_en",   32'(bad_en),    32'd0);
      check("rr_no_pop_cnt",  32'(bad_count), 32'd0);
      wait_drain("rr");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command front-end that sits directly upstream of `i2c_master` and replaces hand-written stimulus sequencing with hardware. It queues register read/write commands in a small FIFO and drives the master's `i_enable`/`i_rw`/`i_reg_addr`/`i_mosi_data` handshake one transaction at a time. It waits on `o_busy` edges, captures read data, and returns one response per command, with a timeout error if the master never starts.

## Interface
Parameters:
- DATA_WIDTH, 8, data byte width (matches master)
- REG_WIDTH, 8, register address width (matches master)
- ADDR_WIDTH, 7, I2C device address width (matches master)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 1024, cycles allowed in ARM for busy to rise

Ports:
- i_clk  in  1  system clock; one clock domain, no other clocks
- i_rst  in  1  synchronous, active-high reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  FIFO not full
- i_cmd_rw  in  1  0=write, 1=read
- i_cmd_reg  in  REG_WIDTH  target register
- i_cmd_data  in  DATA_WIDTH  write data (ignored for reads)
- i_device_addr  in  ADDR_WIDTH  slave address, sampled at pop
- i_divider  in  16  SCL divider, sampled at pop
- o_enable  out  1  to master i_enable
- o_rw  out  1  to master i_rw
- o_reg_addr  out  REG_WIDTH  to master i_reg_addr
- o_mosi_data  out  DATA_WIDTH  to master i_mosi_data
- o_device_addr  out  ADDR_WIDTH  to master i_device_addr
- o_divider  out  16  to master i_divider
- i_miso_data  in  DATA_WIDTH  from master o_miso_data
- i_busy  in  1  from master o_busy
- o_rsp_valid  out  1  response held
- i_rsp_ready  in  1  response consumed
- o_rsp_rw, o_rsp_reg, o_rsp_data, o_rsp_err  out  1/REG_WIDTH/DATA_WIDTH/1  response fields
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  queued commands
- o_idle  out  1  state IDLE and FIFO empty

## Operation
- FIFO: push on `i_cmd_valid & o_cmd_ready`. `o_cmd_ready = (count != FIFO_DEPTH)`, combinational from count, with no full-bypass. Pop happens only in IDLE. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: if count>0 and `i_busy==0`: pop and register rw/reg/data plus sampled device_addr/divider onto master outputs; go LOAD. If `i_busy==1`, stay in IDLE; a foreign transaction is still in flight.
- LOAD: `o_enable<=1`, clear timeout counter; go ARM.
- ARM: if `i_busy==1`, then `o_enable<=0` and go RUN. Else increment counter; at counter==TIMEOUT-1, `o_enable<=0`, `err<=1`, go DONE.
- RUN: on `i_busy==0`, if rw then `o_rsp_data<=i_miso_data`, else `o_rsp_data<=o_mosi_data` (echo). `err<=0`; go DONE.
- DONE: `o_rsp_valid=1` with all response fields stable until `i_rsp_ready`. On the handshake cycle, drop valid and go IDLE. Every command, read or write, yields exactly one response.
- On timeout, `o_rsp_data` = 0.

## Timing
- Reset: all outputs 0 except `o_idle=1`. `o_cmd_ready=1`, FIFO flushed, state IDLE, counter 0.
- Reset mid-transaction: `o_enable` is 0 after the reset edge. The master is not aborted; after reset the block waits in IDLE for `i_busy==0` before the next pop.
- Command accepted at edge N → count visible N+1 → pop at edge N+1 (if idle and not busy) → master address/data outputs valid after N+1 → `o_enable` high after N+2. Address/data lead enable by exactly one cycle and stay stable until the next pop.
- `o_enable` falls on the edge after `i_busy` is first sampled high, giving a minimum enable pulse of 1 cycle.
- `i_busy` already high in LOAD is caught in the first ARM cycle.
- The response appears on the edge after busy is sampled low. Minimum IDLE→IDLE for one command with ready held high = 4 cycles plus master busy time.
- Back-to-back commands: the next pop happens on the cycle after the DONE handshake, if the FIFO is non-empty.

## Test plan
- Reset: hold `i_rst` 3 cycles → all outputs 0, `o_idle=1`, `o_cmd_ready=1`, `o_fifo_count=0`.
- Write then read with the real `i2c_master` + `i2c_slave` at device 7'h11: write reg 0x00=0xDC, then read reg 0x00 → read response `o_rsp_data=0xDC`, `o_rsp_err=0`, one enable pulse per command.
- Queue writes 0xDC/0xAB/0xEF to regs 0–2 plus a read of reg 1, back-to-back → count peaks at 4 and `o_cmd_ready=0` while full; a 5th push while full is not accepted. Responses come back in order; the read returns 0xAB.
- Timeout: stub `i_busy` stuck 0, TIMEOUT=16 → `o_enable` high exactly 16 cycles, then response with `o_rsp_err=1`, `o_rsp_data=0`.
- Backpressure: hold `i_rsp_ready=0` for 50 cycles after a read → response fields stable throughout, no new `o_enable` pulse, queued commands stay in the FIFO.
- Reset during RUN: `o_enable` low and FIFO empty after the reset edge. With `i_busy` still high, no pop occurs until busy falls, then a newly pushed command proceeds normally.
